// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen_if
// Description : Raster timing bundle carried from the sync generator to the
//               downstream colour-pattern / pixel stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_gen_if;
  logic [10:0] count_h;      // current pixel column
  logic [10:0] count_v;      // current line
  logic        EA;           // visible-area flag
  logic        hsync;        // horizontal sync, polarity set by generator
  logic        vsync;        // vertical sync, polarity set by generator
  logic        frame_start;  // one-clock pulse on the step to (0,0)

  // Timing generator side
  modport master (
    output count_h,
    output count_v,
    output EA,
    output hsync,
    output vsync,
    output frame_start
  );

  // Consumer side (pixel stage, monitor driver)
  modport slave (
    input count_h,
    input count_v,
    input EA,
    input hsync,
    input vsync,
    input frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : Raster timing generator. Produces pixel/line counters, the
//               visible-area flag and hsync/vsync pulses. Each axis runs a
//               phase FSM (ACTIVE/FRONT/SYNC/BACK); all outputs are decoded
//               from next-state values so they line up with the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int H_VIS  = 1024,
  parameter int H_FP   = 24,
  parameter int H_SYNC = 136,
  parameter int H_BP   = 160,
  parameter int V_VIS  = 768,
  parameter int V_FP   = 3,
  parameter int V_SYNC = 6,
  parameter int V_BP   = 29,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        pix_ce,
  vga_sync_gen_if.master   vga
);

  // Line/frame geometry. Totals must fit the 11-bit counters (<= 2048).
  localparam int          c_H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int          c_V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] c_H_LAST       = 11'(c_H_TOTAL - 1);
  localparam logic [10:0] c_V_LAST       = 11'(c_V_TOTAL - 1);
  localparam logic [10:0] c_H_FRONT_AT   = 11'(H_VIS);
  localparam logic [10:0] c_H_SYNC_AT    = 11'(H_VIS + H_FP);
  localparam logic [10:0] c_H_BACK_AT    = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] c_V_FRONT_AT   = 11'(V_VIS);
  localparam logic [10:0] c_V_SYNC_AT    = 11'(V_VIS + V_FP);
  localparam logic [10:0] c_V_BACK_AT    = 11'(V_VIS + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } phase_t;

  // Phase advance: a phase is left exactly when the next counter value
  // reaches the first position of the following phase.
  function automatic phase_t phase_next(
    input phase_t      cur,
    input logic [10:0] nxt,
    input logic [10:0] front_at,
    input logic [10:0] sync_at,
    input logic [10:0] back_at
  );
    phase_t n;
    n = cur;
    case (cur)
      ST_ACTIVE: if (nxt == front_at) n = ST_FRONT;
      ST_FRONT:  if (nxt == sync_at)  n = ST_SYNC;
      ST_SYNC:   if (nxt == back_at)  n = ST_BACK;
      ST_BACK:   if (nxt == 11'd0)    n = ST_ACTIVE;
      default:   n = ST_BACK;
    endcase
    return n;
  endfunction

  logic [10:0] r_count_h;
  logic [10:0] r_count_v;
  phase_t      r_h_state;
  phase_t      r_v_state;
  logic        r_ea;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_frame_start;

  logic [10:0] w_h_nxt;
  logic [10:0] w_v_nxt;
  logic        w_h_wrap;
  phase_t      w_h_state_nxt;
  phase_t      w_v_state_nxt;

  // Next counter positions and phases; the vertical axis only moves on an h-wrap.
  always_comb begin
    w_h_wrap      = (r_count_h == c_H_LAST);
    w_h_nxt       = w_h_wrap ? 11'd0 : r_count_h + 11'd1;
    w_v_nxt       = r_count_v;
    w_h_state_nxt = phase_next(r_h_state, w_h_nxt, c_H_FRONT_AT, c_H_SYNC_AT, c_H_BACK_AT);
    w_v_state_nxt = r_v_state;
    if (w_h_wrap) begin
      w_v_nxt       = (r_count_v == c_V_LAST) ? 11'd0 : r_count_v + 11'd1;
      w_v_state_nxt = phase_next(r_v_state, w_v_nxt, c_V_FRONT_AT, c_V_SYNC_AT, c_V_BACK_AT);
    end
  end

  // Counters, phase FSMs and registered output decode; reset parks on the last
  // back-porch pixel so the first enabled clock starts a complete frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count_h     <= c_H_LAST;
      r_count_v     <= c_V_LAST;
      r_h_state     <= ST_BACK;
      r_v_state     <= ST_BACK;
      r_ea          <= 1'b0;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (pix_ce) begin
        r_count_h     <= w_h_nxt;
        r_count_v     <= w_v_nxt;
        r_h_state     <= w_h_state_nxt;
        r_v_state     <= w_v_state_nxt;
        r_ea          <= (w_h_state_nxt == ST_ACTIVE) && (w_v_state_nxt == ST_ACTIVE);
        r_hsync       <= (w_h_state_nxt == ST_SYNC) ? H_POL : ~H_POL;
        r_vsync       <= (w_v_state_nxt == ST_SYNC) ? V_POL : ~V_POL;
        r_frame_start <= (w_h_nxt == 11'd0) && (w_v_nxt == 11'd0);
      end
    end
  end

  assign vga.count_h     = r_count_h;
  assign vga.count_v     = r_count_v;
  assign vga.EA          = r_ea;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire
